bcd_addsub_serial: RTL and testbench

- Parametrised, digit-serial BCD modular adder/subtractor; the successor to the single-digit mod-10 combinational add/sub.
- Computes (x + y) mod 10^DIGITS or (x − y) mod 10^DIGITS on packed BCD operands, one digit per clock, LSD first.
- Has valid/ready handshakes on input and output, plus carry/borrow-out and invalid-digit reporting.
- Sits between the operand register file and the display/result path.

---
 rtl/bcd_addsub_serial.sv | 153 +++++++++++++++
 tb/tb_bcd_addsub_serial.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD modular adder/subtractor with valid/ready handshakes.
// One digit per clock, least-significant digit first; result held until consumed.
module bcd_addsub_serial #(
    parameter  int DIGITS = 4,
    localparam int CW     = $clog2(DIGITS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  s,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   z,
    output logic                  cout,
    output logic                  err
);

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; valid holds its payload stable until that edge.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [4*DIGITS-1:0] x_q, y_q;
    logic                s_q;
    logic                c_q, c_d;
    logic                err_pend_q;
    logic [4*DIGITS-1:0] zs_q, zs_d;
    logic [4*DIGITS-1:0] z_q;
    logic                cout_q;
    logic                err_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [CW+1:0]       base;
    logic [3:0]          xd, yd, dig;
    logic [4:0]          sum_t, dif_t, adj_t;
    logic                bad_digit;
    logic                last;

    assign base = {cnt_q, 2'b00};
    assign xd   = x_q[base +: 4];
    assign yd   = y_q[base +: 4];
    assign last = (cnt_q == CW'(DIGITS - 1));

    always_comb begin
        sum_t = {1'b0, xd} + {1'b0, yd} + {4'b0000, c_q};
        dif_t = {1'b0, xd} - {1'b0, yd} - {4'b0000, c_q};
        adj_t = 5'd0;
        dig   = 4'd0;
        c_d   = 1'b0;
        if (!s_q) begin
            if (sum_t > 5'd9) begin
                adj_t = sum_t - 5'd10;
                dig   = adj_t[3:0];
                c_d   = 1'b1;
            end else begin
                dig   = sum_t[3:0];
            end
        end else begin
            // dif_t spans -16..15, so bit 4 is the sign of the digit difference
            if (dif_t[4]) begin
                adj_t = dif_t + 5'd10;
                dig   = adj_t[3:0];
                c_d   = 1'b1;
            end else begin
                dig   = dif_t[3:0];
            end
        end
    end

    always_comb begin
        zs_d = zs_q;
        zs_d[base +: 4] = dig;
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            s_q         <= 1'b0;
            c_q         <= 1'b0;
            err_pend_q  <= 1'b0;
            zs_q        <= '0;
            z_q         <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= x;
                        y_q        <= y;
                        s_q        <= s;
                        c_q        <= 1'b0;
                        cnt_q      <= '0;
                        err_pend_q <= bad_digit;
                        zs_q       <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    c_q  <= c_d;
                    zs_q <= zs_d;
                    if (last) begin
                        // Visible result registers change only here
                        z_q         <= err_pend_q ? '0 : zs_d;
                        cout_q      <= err_pend_q ? 1'b0 : c_d;
                        err_q       <= err_pend_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: a 4-digit instance for the main
// scenarios and a 1-digit instance for the exhaustive single-digit sweep.
module tb_bcd_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic        in_valid4 = 0, s4 = 0, out_ready4 = 0;
  logic [15:0] x4 = '0, y4 = '0;
  logic        in_ready4, out_valid4, cout4, err4;
  logic [15:0] z4;

  // 1-digit instance
  logic        in_valid1 = 0, s1 = 0, out_ready1 = 0;
  logic [3:0]  x1 = '0, y1 = '0;
  logic        in_ready1, out_valid1, cout1, err1;
  logic [3:0]  z1;

  bcd_addsub_serial #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .s(s4), .x(x4), .y(y4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .z(z4), .cout(cout4), .err(err4)
  );

  bcd_addsub_serial #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .s(s1), .x(x1), .y(y1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .z(z1), .cout(cout1), .err(err1)
  );

  int checks = 0;
  int failures = 0;
  logic [17:0] exp4_q[$];
  logic [17:0] exp1_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model via integer arithmetic: returns {err, cout, z}
  function automatic logic [17:0] model(input int d, input logic sm,
                                        input logic [15:0] xv, input logic [15:0] yv);
    longint xi = 0, yi = 0, m = 1, r;
    logic bad = 0, c;
    logic [15:0] zr = '0;
    for (int i = d - 1; i >= 0; i--) begin
      int xn, yn;
      xn = int'((xv >> (4 * i)) & 16'hF);
      yn = int'((yv >> (4 * i)) & 16'hF);
      if (xn > 9 || yn > 9) bad = 1;
      xi = xi * 10 + xn;
      yi = yi * 10 + yn;
      m  = m * 10;
    end
    if (bad) return {1'b1, 1'b0, 16'h0};
    if (!sm) begin
      r = xi + yi;
      c = (r >= m);
      if (c) r = r - m;
    end else begin
      c = (xi < yi);
      r = xi - yi;
      if (c) r = r + m;
    end
    for (int i = 0; i < d; i++) begin
      zr = zr | (16'(r % 10) << (4 * i));
      r = r / 10;
    end
    return {1'b0, c, zr};
  endfunction

  task automatic drive4(input logic sm, input logic [15:0] xv, input logic [15:0] yv,
                        input int hold);
    int n, lat;
    logic [17:0] e;
    @(negedge clk);
    s4 = sm; x4 = xv; y4 = yv; in_valid4 = 1;
    n = 0;
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", 0, 1);
    exp4_q.push_back(model(4, sm, xv, yv));
    @(posedge clk); #1;
    in_valid4 = 0;
    s4 = 1'($urandom_range(0, 1)); x4 = 16'($urandom); y4 = 16'($urandom);
    out_ready4 = 1;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      check("in_ready_run", in_ready4, 0);
      @(posedge clk); #1; lat++;
    end
    check("latency4", lat, 4);
    out_ready4 = 0;
    e = exp4_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", out_valid4, 1);
      check("bp_in_ready", in_ready4, 0);
      check("bp_z", z4, e[15:0]);
      @(posedge clk); #1;
    end
    check("z4", z4, e[15:0]);
    check("cout4", cout4, e[16]);
    check("err4", err4, e[17]);
    out_ready4 = 1;
    @(posedge clk); #1;
    out_ready4 = 0;
    check("valid_drop", out_valid4, 0);
    check("in_ready_back", in_ready4, 1);
    check("z4_kept", z4, e[15:0]);
  endtask

  task automatic drive1(input logic sm, input logic [3:0] xv, input logic [3:0] yv);
    int lat;
    logic [17:0] e;
    @(negedge clk);
    s1 = sm; x1 = xv; y1 = yv; in_valid1 = 1;
    exp1_q.push_back(model(1, sm, {12'h0, xv}, {12'h0, yv}));
    @(posedge clk); #1;
    in_valid1 = 0;
    out_ready1 = 1;
    lat = 0;
    while (!out_valid1 && lat < 10) begin @(posedge clk); #1; lat++; end
    check("latency1", lat, 1);
    e = exp1_q.pop_front();
    check("z1", z1, e[3:0]);
    check("cout1", cout1, e[16]);
    check("err1", err1, e[17]);
    @(posedge clk); #1;
    out_ready1 = 0;
    check("valid1_drop", out_valid1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready4, 1);
    check("rst_out_valid", out_valid4, 0);
    check("rst_z", z4, 0);
    check("rst_cout", cout4, 0);
    check("rst_err", err4, 0);
    @(negedge clk);
    rst_n = 1;

    drive4(0, 16'h1234, 16'h5678, 0);
    drive4(0, 16'h9999, 16'h0001, 0);
    drive4(1, 16'h0003, 16'h0007, 0);
    drive4(1, 16'h5000, 16'h4999, 0);
    drive4(0, 16'h1111, 16'h2222, 3);
    drive4(0, 16'h00A0, 16'h0001, 0);
    drive4(1, 16'h1234, 16'h00F0, 1);

    for (int k = 0; k < 10; k++) begin
      logic [15:0] xr, yr;
      for (int d = 0; d < 4; d++) begin
        xr[4*d +: 4] = 4'($urandom_range(0, 9));
        yr[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      drive4(1'($urandom_range(0, 1)), xr, yr, $urandom_range(0, 2));
    end

    for (int sm = 0; sm < 2; sm++)
      for (int xa = 0; xa < 10; xa++)
        for (int yb = 0; yb < 10; yb++)
          drive1(1'(sm), 4'(xa), 4'(yb));

    // Abort in the middle of RUN: partial result must never appear
    @(negedge clk);
    s4 = 0; x4 = 16'h5555; y4 = 16'h5555; in_valid4 = 1;
    @(posedge clk); #1;
    in_valid4 = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("mid_rst_valid", out_valid4, 0);
    check("mid_rst_z", z4, 0);
    check("mid_rst_in_ready", in_ready4, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_rst_hold_valid", out_valid4, 0);
    end
    @(negedge clk);
    rst_n = 1;
    drive4(0, 16'h0001, 16'h0001, 0);

    check("queue4_empty", exp4_q.size(), 0);
    check("queue1_empty", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
